// File: rtl/pipeline_defs_pkg.sv
// rtl/pipeline_defs_pkg.sv - shared pipeline constants, IF/ID field layout and IF FSM encoding
//
// Contents:
//   RESET_PC_DEFAULT  : PC value loaded on reset unless overridden
//   IFID_W            : IF/ID register width
//   IFID_PC_MSB/LSB   : PC+4 field of the IF/ID register
//   IFID_INSTR_MSB/LSB: instruction-word field of the IF/ID register
//   NOP_INSTR         : instruction word used for bubbles
//   if_state_e        : IF-stage FSM state encoding
//   pc_plus4()        : 32-bit PC increment, wraps modulo 2^32
package pipeline_defs;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  localparam int IFID_W         = 64;
  localparam int IFID_PC_MSB    = 63;
  localparam int IFID_PC_LSB    = 32;
  localparam int IFID_INSTR_MSB = 31;
  localparam int IFID_INSTR_LSB = 0;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // FETCH: request outstanding. HELD: skid buffer occupied, no request.
  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_HELD  = 1'b1
  } if_state_e;

  // Plain 32-bit add; the carry out is intentionally dropped.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// rtl/if_skid_buf.sv - one-entry 64-bit holding register with load, clear and full flag
//
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset, empties the buffer
//   load  in   capture din and mark full
//   clear in   empty the buffer; takes priority over load
//   din   in   [IFID_W-1:0] entry to capture
//   dout  out  [IFID_W-1:0] held entry (zero when empty)
//   full  out  buffer holds a valid entry
module if_skid_buf
  import pipeline_defs::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [IFID_W-1:0] din,
  output logic [IFID_W-1:0] dout,
  output logic              full
);

  logic [IFID_W-1:0] data_q, data_d;
  logic              full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (clear) begin
      data_d = '0;
      full_d = 1'b0;
    end else if (load) begin
      data_d = din;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign dout = data_q;
  assign full = full_q;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage: PC, imem handshake, IF/ID register, skid buffer
//
// Ports:
//   clk            in   pipeline clock, rising edge
//   rst            in   synchronous active-high reset
//   stall          in   ID cannot accept; hold IF/ID
//   flush          in   load a bubble into IF/ID, drop the skid entry
//   redirect_valid in   next PC is redirect_pc instead of pc+4
//   redirect_pc    in   [31:0] redirect target, low two bits forced to 0
//   imem_req       out  fetch request valid
//   imem_addr      out  [31:0] fetch address, equals pc
//   imem_ready     in   imem_rdata valid for imem_addr this cycle
//   imem_rdata     in   [31:0] fetched instruction word
//   pc             out  [31:0] current fetch PC
//   ifid_reg       out  [63:0] {pc+4, instruction}
//   ifid_valid     out  ifid_reg holds a real instruction
module if_stage
  import pipeline_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       pc,
  output logic [IFID_W-1:0] ifid_reg,
  output logic              ifid_valid
);

  logic [31:0]       pc_q, pc_d;
  logic [IFID_W-1:0] ifid_q, ifid_d;
  logic              ifid_valid_q, ifid_valid_d;
  if_state_e         state_q, state_d;

  logic              fetched;
  logic [31:0]       pc_inc;
  logic [31:0]       redirect_aligned;
  logic [IFID_W-1:0] fetch_entry;
  logic              skid_load;
  logic              skid_clear;
  logic [IFID_W-1:0] skid_dout;
  logic              skid_full;

  // The memory answers combinationally, so a fetch completes in the same
  // cycle it is requested. Data returned while rst is high is ignored.
  assign fetched          = (state_q == ST_FETCH) && imem_ready && !rst;
  assign pc_inc           = pc_plus4(pc_q);
  assign redirect_aligned = redirect_pc & ~32'h3;

  always_comb begin
    fetch_entry = '0;
    fetch_entry[IFID_PC_MSB:IFID_PC_LSB]       = pc_inc;
    fetch_entry[IFID_INSTR_MSB:IFID_INSTR_LSB] = imem_rdata;
  end

  // PC mux: a redirect is honoured in every state, even while stalled.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_aligned;
    end else if (fetched) begin
      pc_d = pc_inc;
    end
  end

  // IF/ID and FSM next state. A redirect without flush leaves the
  // delay-slot instruction alone, so it is not consulted here.
  always_comb begin
    ifid_d       = ifid_q;
    ifid_valid_d = ifid_valid_q;
    state_d      = state_q;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;

    if (flush) begin
      ifid_d       = '0;
      ifid_valid_d = 1'b0;
      skid_clear   = 1'b1;
      state_d      = ST_FETCH;
    end else if (stall) begin
      if (fetched) begin
        skid_load = 1'b1;
        state_d   = ST_HELD;
      end
    end else if (state_q == ST_HELD) begin
      // Drain the buffered instruction; fetching resumes next cycle at pc.
      ifid_d       = skid_full ? skid_dout : '0;
      ifid_valid_d = skid_full;
      skid_clear   = 1'b1;
      state_d      = ST_FETCH;
    end else if (fetched) begin
      ifid_d       = fetch_entry;
      ifid_valid_d = 1'b1;
    end else begin
      ifid_d       = '0;
      ifid_d[IFID_INSTR_MSB:IFID_INSTR_LSB] = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      ifid_q       <= '0;
      ifid_valid_q <= 1'b0;
      state_q      <= ST_FETCH;
    end else begin
      pc_q         <= pc_d;
      ifid_q       <= ifid_d;
      ifid_valid_q <= ifid_valid_d;
      state_q      <= state_d;
    end
  end

  if_skid_buf u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .din   (fetch_entry),
    .dout  (skid_dout),
    .full  (skid_full)
  );

  assign imem_req   = !rst && (state_q == ST_FETCH);
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign ifid_reg   = ifid_q;
  assign ifid_valid = ifid_valid_q;

endmodule
